// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
//   - state_t      : main controller state encoding
//   - OP_*         : the opcodes the controller dispatches on
//   - ALUOP_*, SRCA_*, SRCB_*, RES_* : datapath mux / ALU-control encodings
//   - is_mem_wait_state() : states that issue a memory request and may wait
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        MEM_ADR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        BRANCH,
        FAULT
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    function automatic logic is_mem_wait_state(state_t s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter with timeout detect.
//   clk, reset : core clock, async active-high reset
//   clear      : zero the counter (entry into a memory-wait state)
//   req, ready : memory request valid / memory completes this cycle
//   expired    : request still pending on its last allowed cycle
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic req,
    input  logic ready,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    // Never needs to count past TIMEOUT-1: expiry sends the controller
    // to a state that stops requesting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (req && !ready)
            cnt <= cnt + CW'(1);
    end

    // A completing transfer on the final cycle is not a timeout.
    assign expired = req && !ready && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core.
//   clk, reset          : core clock, async active-high reset
//   Opcode              : IR[6:0], looked at only in DECODE
//   Zero                : ALU zero flag, looked at only in BRANCH
//   MemReady            : memory completes the current request
//   MemReq/MemWrite/AdrSrc           : unified memory port control
//   IRWrite/PCWrite/RegWrite         : architectural write enables
//   ALUSrcA/ALUSrcB/ALUOp/ResultSrc  : datapath steering
//   Fault               : sticky illegal-opcode / memory-timeout flag
//   InstrCount          : retired instruction count (wraps)
module multicycle_control_fsm
    import core_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ResultSrc,
    output logic             Fault,
    output logic [CNT_W-1:0] InstrCount
);

    state_t state, next_state;
    logic   is_store;
    logic   timeout;
    logic   wait_clear;
    logic   retire;

    // Load/store choice is captured in DECODE so MEM_ADR does not depend
    // on Opcode staying stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            is_store   <= 1'b0;
            InstrCount <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE)
                is_store <= (Opcode == OP_SW);
            if (retire)
                InstrCount <= InstrCount + CNT_W'(1);
        end
    end

    // Restart the wait budget each time a memory-wait state is entered.
    assign wait_clear = (next_state != state) && is_mem_wait_state(next_state);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .req     (MemReq),
        .ready   (MemReady),
        .expired (timeout)
    );

    assign retire = (state == ALU_WB) || (state == MEM_WB) || (state == BRANCH) ||
                    ((state == MEM_WR) && MemReady);

    always_comb begin
        next_state = state;
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_ADD;
        ResultSrc  = RES_ALUOUT;
        Fault      = 1'b0;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                MemReq  = 1'b1;
                ALUSrcA = SRCA_PC;
                ALUSrcB = SRCB_FOUR;
                ALUOp   = ALUOP_ADD;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = DECODE;
                end else if (timeout) begin
                    next_state = FAULT;
                end
            end
            DECODE: begin
                // Branch target (OldPC + imm) lands in ALUOut here.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
                case (Opcode)
                    OP_R:          next_state = EXEC_R;
                    OP_I:          next_state = EXEC_I;
                    OP_LW, OP_SW:  next_state = MEM_ADR;
                    OP_BEQ:        next_state = BRANCH;
                    default:       next_state = FAULT;
                endcase
            end
            EXEC_R: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = ALUOP_FUNCT;
                next_state = ALU_WB;
            end
            EXEC_I: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALUOP_FUNCT;
                next_state = ALU_WB;
            end
            ALU_WB: begin
                RegWrite   = 1'b1;
                ResultSrc  = RES_ALUOUT;
                next_state = FETCH;
            end
            MEM_ADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALUOP_ADD;
                next_state = is_store ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady)
                    next_state = MEM_WB;
                else if (timeout)
                    next_state = FAULT;
            end
            MEM_WB: begin
                RegWrite   = 1'b1;
                ResultSrc  = RES_MEMDATA;
                next_state = FETCH;
            end
            MEM_WR: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (MemReady)
                    next_state = FETCH;
                else if (timeout)
                    next_state = FAULT;
            end
            BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = ALUOP_SUB;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = Zero;
                next_state = FETCH;
            end
            FAULT: Fault = 1'b1;
            default: next_state = FAULT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;
    import core_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  Opcode = 7'd0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Fault;
    logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [31:0] InstrCount;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,SrcA,SrcB,ALUOp,ResultSrc,Fault}
    localparam logic [14:0] C_IDLE      = 15'b0_0_0_0_0_0_00_00_00_00_0;
    localparam logic [14:0] C_FETCH     = 15'b1_0_0_0_0_0_00_10_00_00_0;
    localparam logic [14:0] C_FETCH_RDY = 15'b1_0_0_1_1_0_00_10_00_00_0;
    localparam logic [14:0] C_DECODE    = 15'b0_0_0_0_0_0_01_01_00_00_0;
    localparam logic [14:0] C_EXEC_R    = 15'b0_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] C_EXEC_I    = 15'b0_0_0_0_0_0_10_01_10_00_0;
    localparam logic [14:0] C_ALU_WB    = 15'b0_0_0_0_0_1_00_00_00_00_0;
    localparam logic [14:0] C_MEM_ADR   = 15'b0_0_0_0_0_0_10_01_00_00_0;
    localparam logic [14:0] C_MEM_RD    = 15'b1_0_1_0_0_0_00_00_00_00_0;
    localparam logic [14:0] C_MEM_WB    = 15'b0_0_0_0_0_1_00_00_00_01_0;
    localparam logic [14:0] C_MEM_WR    = 15'b1_1_1_0_0_0_00_00_00_00_0;
    localparam logic [14:0] C_BR1       = 15'b0_0_0_0_1_0_10_00_01_00_0;
    localparam logic [14:0] C_BR0       = 15'b0_0_0_0_0_0_10_00_01_00_0;
    localparam logic [14:0] C_FAULT     = 15'b0_0_0_0_0_0_00_00_00_00_1;

    multicycle_control_fsm #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .MemReq     (MemReq),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ResultSrc  (ResultSrc),
        .Fault      (Fault),
        .InstrCount (InstrCount)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] ctl();
        return {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Fault};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset, releases it, and leaves the FSM in its first FETCH cycle.
    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (ctl() !== C_IDLE) begin errors++; $display("FAIL reset_outputs: got %b want %b", ctl(), C_IDLE); end
        checks++; if (InstrCount !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", InstrCount); end
        step();
        reset = 1'b0;
        MemReady = 1'b0;
        exp_cnt = 32'd0;
        #1;
        checks++; if (dut.state !== IDLE || ctl() !== C_IDLE) begin errors++; $display("FAIL reset_idle: got state %0d ctl %b want IDLE ctl %b", dut.state, ctl(), C_IDLE); end
        step();
        #1;
        checks++; if (dut.state !== FETCH || ctl() !== C_FETCH) begin errors++; $display("FAIL reset_to_fetch: got state %0d ctl %b want FETCH ctl %b", dut.state, ctl(), C_FETCH); end
    endtask

    task automatic test_rtype();
        Opcode = OP_R; MemReady = 1'b1; #1;
        checks++; if (ctl() !== C_FETCH_RDY) begin errors++; $display("FAIL r_fetch_ready: got %b want %b", ctl(), C_FETCH_RDY); end
        step(); MemReady = 1'b0; #1;
        checks++; if (ctl() !== C_DECODE) begin errors++; $display("FAIL r_decode: got %b want %b", ctl(), C_DECODE); end
        step(); Opcode = 7'b1111111; #1;
        checks++; if (dut.state !== EXEC_R || ctl() !== C_EXEC_R) begin errors++; $display("FAIL r_exec: got state %0d ctl %b want %b", dut.state, ctl(), C_EXEC_R); end
        step(); #1;
        checks++; if (ctl() !== C_ALU_WB || InstrCount !== exp_cnt) begin errors++; $display("FAIL r_alu_wb: got ctl %b cnt %0d want %b cnt %0d", ctl(), InstrCount, C_ALU_WB, exp_cnt); end
        step(); exp_cnt++; #1;
        checks++; if (ctl() !== C_FETCH || InstrCount !== exp_cnt) begin errors++; $display("FAIL r_retire: got ctl %b cnt %0d want %b cnt %0d", ctl(), InstrCount, C_FETCH, exp_cnt); end
    endtask

    task automatic test_itype();
        Opcode = OP_I; MemReady = 1'b1; #1;
        step(); MemReady = 1'b0; #1;
        step(); #1;
        checks++; if (dut.state !== EXEC_I || ctl() !== C_EXEC_I) begin errors++; $display("FAIL i_exec: got state %0d ctl %b want %b", dut.state, ctl(), C_EXEC_I); end
        step(); step(); exp_cnt++; #1;
        checks++; if (dut.state !== FETCH || InstrCount !== exp_cnt) begin errors++; $display("FAIL i_retire: got state %0d cnt %0d want FETCH cnt %0d", dut.state, InstrCount, exp_cnt); end
    endtask

    task automatic test_lw();
        int cycles = 0;
        int req_cycles = 0;
        Opcode = OP_LW; MemReady = 1'b1; #1;
        step(); cycles++; MemReady = 1'b0; #1;
        step(); cycles++; Opcode = OP_SW; MemReady = 1'b1; #1;   // ignored: no request
        checks++; if (ctl() !== C_MEM_ADR) begin errors++; $display("FAIL lw_mem_adr: got %b want %b", ctl(), C_MEM_ADR); end
        step(); cycles++;
        for (int i = 0; i < 4; i++) begin
            MemReady = (i == 3); #1;
            req_cycles += int'(MemReq);
            checks++; if (dut.state !== MEM_RD || ctl() !== C_MEM_RD) begin errors++; $display("FAIL lw_mem_rd%0d: got state %0d ctl %b want %b", i, dut.state, ctl(), C_MEM_RD); end
            step(); cycles++;
        end
        MemReady = 1'b0; #1;
        req_cycles += int'(MemReq);
        checks++; if (ctl() !== C_MEM_WB) begin errors++; $display("FAIL lw_mem_wb: got %b want %b", ctl(), C_MEM_WB); end
        checks++; if (req_cycles != 4) begin errors++; $display("FAIL lw_req_cycles: got %0d want 4", req_cycles); end
        step(); cycles++; exp_cnt++; #1;
        checks++; if (dut.state !== FETCH || cycles != 8 || InstrCount !== exp_cnt) begin errors++; $display("FAIL lw_total: got state %0d cycles %0d cnt %0d want FETCH 8 %0d", dut.state, cycles, InstrCount, exp_cnt); end
    endtask

    task automatic test_beq();
        logic z;
        for (int k = 0; k < 2; k++) begin
            z = (k == 0);
            Opcode = OP_BEQ; MemReady = 1'b1; Zero = ~z; #1;
            step(); MemReady = 1'b0; #1;
            step(); Zero = z; #1;
            checks++; if (ctl() !== (z ? C_BR1 : C_BR0)) begin errors++; $display("FAIL beq_z%0d: got %b want %b", z, ctl(), z ? C_BR1 : C_BR0); end
            step(); Zero = 1'b1; exp_cnt++; #1;
            checks++; if (PCWrite !== 1'b0 || InstrCount !== exp_cnt) begin errors++; $display("FAIL beq_retire%0d: got pcw %b cnt %0d want 0 cnt %0d", k, PCWrite, InstrCount, exp_cnt); end
            Zero = 1'b0;
        end
    endtask

    task automatic test_sw();
        Opcode = OP_SW; MemReady = 1'b1; #1;
        step(); MemReady = 1'b0; #1;
        step(); Opcode = OP_LW; #1;
        step(); #1;
        checks++; if (dut.state !== MEM_WR || ctl() !== C_MEM_WR) begin errors++; $display("FAIL sw_mem_wr: got state %0d ctl %b want %b", dut.state, ctl(), C_MEM_WR); end
        step(); #1;
        checks++; if (dut.state !== MEM_WR || InstrCount !== exp_cnt) begin errors++; $display("FAIL sw_wait: got state %0d cnt %0d want MEM_WR cnt %0d", dut.state, InstrCount, exp_cnt); end
        MemReady = 1'b1; #1;
        step(); MemReady = 1'b0; exp_cnt++; #1;
        checks++; if (dut.state !== FETCH || InstrCount !== exp_cnt) begin errors++; $display("FAIL sw_retire: got state %0d cnt %0d want FETCH cnt %0d", dut.state, InstrCount, exp_cnt); end
    endtask

    task automatic test_timeout_ok();
        MemReady = 1'b0; Opcode = OP_R;
        repeat (15) begin #1; step(); end
        checks++; if (dut.state !== FETCH || ctl() !== C_FETCH) begin errors++; $display("FAIL tmo_ok_cycle16: got state %0d ctl %b want FETCH %b", dut.state, ctl(), C_FETCH); end
        MemReady = 1'b1; #1;
        step(); MemReady = 1'b0; #1;
        checks++; if (dut.state !== DECODE || Fault !== 1'b0) begin errors++; $display("FAIL tmo_ok_decode: got state %0d fault %b want DECODE 0", dut.state, Fault); end
        step(); step(); step(); exp_cnt++; #1;
        checks++; if (dut.state !== FETCH || InstrCount !== exp_cnt) begin errors++; $display("FAIL tmo_ok_retire: got state %0d cnt %0d want FETCH %0d", dut.state, InstrCount, exp_cnt); end
    endtask

    task automatic test_timeout_fault();
        MemReady = 1'b0;
        repeat (15) begin #1; step(); end
        checks++; if (dut.state !== FETCH) begin errors++; $display("FAIL tmo_cycle16: got state %0d want FETCH", dut.state); end
        step(); #1;
        checks++; if (dut.state !== FAULT || ctl() !== C_FAULT) begin errors++; $display("FAIL tmo_fault: got state %0d ctl %b want FAULT %b", dut.state, ctl(), C_FAULT); end
        MemReady = 1'b1; Opcode = OP_R;
        repeat (4) step();
        #1;
        checks++; if (ctl() !== C_FAULT || InstrCount !== exp_cnt) begin errors++; $display("FAIL tmo_sticky: got ctl %b cnt %0d want %b cnt %0d", ctl(), InstrCount, C_FAULT, exp_cnt); end
        MemReady = 1'b0;
    endtask

    task automatic test_illegal();
        Opcode = 7'b1111111; MemReady = 1'b1; #1;
        step(); MemReady = 1'b0; #1;
        checks++; if (ctl() !== C_DECODE) begin errors++; $display("FAIL ill_decode: got %b want %b", ctl(), C_DECODE); end
        step(); #1;
        checks++; if (dut.state !== FAULT || ctl() !== C_FAULT) begin errors++; $display("FAIL ill_fault: got state %0d ctl %b want FAULT %b", dut.state, ctl(), C_FAULT); end
        Opcode = OP_R; MemReady = 1'b1;
        repeat (3) step();
        #1;
        checks++; if (ctl() !== C_FAULT || InstrCount !== exp_cnt) begin errors++; $display("FAIL ill_sticky: got ctl %b cnt %0d want %b cnt %0d", ctl(), InstrCount, C_FAULT, exp_cnt); end
        MemReady = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        Opcode = OP_SW; MemReady = 1'b1; #1;
        step(); MemReady = 1'b0; #1;
        step(); step(); #1;
        checks++; if (MemReq !== 1'b1 || MemWrite !== 1'b1) begin errors++; $display("FAIL rmw_pre: got req %b wr %b want 1 1", MemReq, MemWrite); end
        reset = 1'b1; #1;   // well before the next rising edge
        checks++; if (MemReq !== 1'b0 || MemWrite !== 1'b0 || RegWrite !== 1'b0 || InstrCount !== 32'd0) begin errors++; $display("FAIL rmw_async: got req %b wr %b rw %b cnt %0d want 0 0 0 0", MemReq, MemWrite, RegWrite, InstrCount); end
        step(); reset = 1'b0; exp_cnt = 32'd0; #1;
        checks++; if (dut.state !== IDLE || ctl() !== C_IDLE) begin errors++; $display("FAIL rmw_idle: got state %0d ctl %b want IDLE", dut.state, ctl()); end
        step(); #1;
        checks++; if (dut.state !== FETCH || InstrCount !== 32'd0) begin errors++; $display("FAIL rmw_fetch: got state %0d cnt %0d want FETCH 0", dut.state, InstrCount); end
    endtask

    initial begin
        #2;
        test_reset();
        test_rtype();
        test_itype();
        test_lw();
        test_beq();
        test_sw();
        test_timeout_ok();
        test_timeout_fault();
        test_reset();
        test_illegal();
        test_reset();
        test_itype();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
